// File: rtl/pool_ofm_writer.sv
// pool_ofm_writer: rounds, saturates and optionally rectifies pooled sums, buffers them
// in a small FIFO for a valid/ready consumer and tags each popped word with its position.
module pool_ofm_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int IFM_SIZE    = 27,
    parameter int KERNEL_POOL = 5,
    parameter int STRIDE_POOL = 1,
    parameter int OFM_SIZE    = (IFM_SIZE - KERNEL_POOL) / STRIDE_POOL + 1,
    parameter int CI          = 3,
    parameter int SHIFT       = 0,
    parameter int RELU        = 0,
    parameter int FIFO_DEPTH  = 8,
    localparam int POS_W      = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1,
    localparam int CH_W       = $clog2(CI) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  data_out,
    output logic [POS_W-1:0]      out_col,
    output logic [POS_W-1:0]      out_row,
    output logic [CH_W-1:0]       out_ch,
    output logic                  ch_done,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [DATA_WIDTH:0] RND =
        (SHIFT > 0) ? ({{DATA_WIDTH{1'b0}}, 1'b1} << RSH) : '0;
    localparam logic signed [DATA_WIDTH:0] SAT_MAX =
        {{(DATA_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] SAT_MIN =
        {{(DATA_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [AW:0]       DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(OFM_SIZE - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CI - 1);

    logic signed [DATA_WIDTH:0] sum;
    logic signed [DATA_WIDTH:0] shifted;
    logic [OUT_WIDTH-1:0]       res;

    logic                  pipe_valid;
    logic [OUT_WIDTH-1:0]  pipe_data;
    logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [OUT_WIDTH-1:0]  hold;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = pipe_valid && (!full || pop);
    assign drop      = pipe_valid && full && !pop;
    // When empty, show the last popped word instead of a stale memory slot.
    assign data_out  = out_valid ? mem[rd_ptr] : hold;

    // Round-half-up, arithmetic shift, signed saturation and optional ReLU.
    always_comb begin
        sum     = $signed({data_in[DATA_WIDTH-1], data_in}) + RND;
        shifted = sum >>> SHIFT;
        if (shifted > SAT_MAX)
            res = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            res = SAT_MIN[OUT_WIDTH-1:0];
        else
            res = shifted[OUT_WIDTH-1:0];
        if (RELU != 0 && res[OUT_WIDTH-1])
            res = '0;
    end

    // FIFO storage; pointers are reset elsewhere, so contents need no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pipe_data;
    end

    // Pipe register, FIFO pointers/occupancy, hold register and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold       <= '0;
            overflow   <= 1'b0;
        end else begin
            pipe_valid <= in_valid;
            if (in_valid)
                pipe_data <= res;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Position counters advance on pops only; end-of-channel/frame pulses follow the pop.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            out_col    <= '0;
            out_row    <= '0;
            out_ch     <= '0;
            ch_done    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ch_done    <= 1'b0;
            frame_done <= 1'b0;
            if (pop) begin
                if (out_col == LAST_POS) begin
                    out_col <= '0;
                    if (out_row == LAST_POS) begin
                        out_row <= '0;
                        ch_done <= 1'b1;
                        if (out_ch == LAST_CH) begin
                            out_ch     <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            out_ch <= out_ch + 1'b1;
                        end
                    end else begin
                        out_row <= out_row + 1'b1;
                    end
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_ofm_writer.sv
// tb_pool_ofm_writer: directed vectors for pool_ofm_writer with hand-computed expectations.
module tb_pool_ofm_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] data_in;
    logic        out_ready;

    logic        ov_def, ov_sh, ov_rl;
    logic [15:0] do_def, do_sh, do_rl;
    logic [4:0]  col_def, col_sh, col_rl;
    logic [4:0]  row_def, row_sh, row_rl;
    logic [2:0]  ch_def, ch_sh, ch_rl;
    logic        cd_def, cd_sh, cd_rl;
    logic        fd_def, fd_sh, fd_rl;
    logic        of_def, of_sh, of_rl;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pool_ofm_writer u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .out_ready(out_ready), .out_valid(ov_def), .data_out(do_def), .out_col(col_def),
        .out_row(row_def), .out_ch(ch_def), .ch_done(cd_def), .frame_done(fd_def),
        .overflow(of_def)
    );

    pool_ofm_writer #(.SHIFT(2)) u_sh (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .out_ready(out_ready), .out_valid(ov_sh), .data_out(do_sh), .out_col(col_sh),
        .out_row(row_sh), .out_ch(ch_sh), .ch_done(cd_sh), .frame_done(fd_sh),
        .overflow(of_sh)
    );

    pool_ofm_writer #(.SHIFT(2), .RELU(1)) u_rl (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .out_ready(out_ready), .out_valid(ov_rl), .data_out(do_rl), .out_col(col_rl),
        .out_row(row_rl), .out_ch(ch_rl), .ch_done(cd_rl), .frame_done(fd_rl),
        .overflow(of_rl)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // One word in, then wait until it has reached the FIFO head.
    task automatic send1(input logic [31:0] v);
        in_valid = 1'b1;
        data_in  = v;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, ov_def, 0);
        check({tag, "_data"},  do_def, 0);
        check({tag, "_col"},   col_def, 0);
        check({tag, "_row"},   row_def, 0);
        check({tag, "_ch"},    ch_def, 0);
        check({tag, "_chd"},   cd_def, 0);
        check({tag, "_frd"},   fd_def, 0);
        check({tag, "_ovf"},   of_def, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_w;
        int sent;
        int n;
        logic popped;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_zero("reset");

        // Latency and rounding: 13 -> 3 with SHIFT=2
        in_valid = 1'b1; data_in = 32'd13;
        tick();
        in_valid = 1'b0;
        check("lat1_valid", ov_sh, 0);
        tick();
        check("lat2_valid", ov_sh, 1);
        check("round_pos", do_sh, 16'h0003);
        check("relu_pos", do_rl, 16'h0003);
        check("noshift_pos", do_def, 16'h000D);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_valid", ov_sh, 0);
        check("hold_data", do_sh, 16'h0003);
        check("pop_col", col_sh, 1);
        do_clear();
        check("clear_data", do_sh, 0);
        check("clear_col", col_sh, 0);
        check("clear_valid", ov_sh, 0);

        // Negative rounding and ReLU: -14 -> -3, ReLU -> 0
        send1(32'hFFFF_FFF2);
        check("round_neg", do_sh, 16'hFFFD);
        check("relu_neg", do_rl, 16'h0000);
        check("noshift_neg", do_def, 16'hFFF2);
        do_clear();

        // Saturation
        send1(32'h0001_0000);
        check("sat_pos", do_def, 16'h7FFF);
        check("sat_pos_sh", do_sh, 16'h4000);
        do_clear();
        send1(32'h8000_0000);
        check("sat_neg", do_def, 16'h8000);
        check("sat_neg_sh", do_sh, 16'h8000);
        check("sat_neg_relu", do_rl, 16'h0000);
        do_clear();

        // Backpressure: 10 words into an 8-deep FIFO
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            data_in  = 32'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        check("bp_overflow", of_def, 1);
        check("bp_valid", ov_def, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_order", do_def, 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        check("bp_empty", ov_def, 0);
        check("bp_hold", do_def, 16'd8);
        check("bp_col", col_def, 8);
        check("bp_sticky", of_def, 1);

        // Reset asserted in the middle of traffic
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data_in  = 32'h55;
            tick();
        end
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check_zero("postrst");
        send1(32'd7);
        check("postrst_data", do_def, 16'd7);
        check("postrst_col0", col_def, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("postrst_col1", col_def, 1);

        // Push and pop together on a full FIFO
        do_clear();
        check("full_ovf_clr", of_def, 0);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            data_in  = 32'(100 + i);
            tick();
        end
        check("full_valid", ov_def, 1);
        check("full_ovf0", of_def, 0);
        exp_w = 100;
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1;
            data_in  = 32'(109 + j);
            check("full_stream", do_def, 32'(exp_w));
            tick();
            exp_w++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && ov_def; k++) begin
            check("full_drain", do_def, 32'(exp_w));
            tick();
            exp_w++;
        end
        check("full_count", 32'(exp_w), 129);
        check("full_no_ovf", of_def, 0);

        // Framing over a full 3 x 23 x 23 frame
        do_clear();
        out_ready = 1'b1;
        sent = 0;
        n = 0;
        for (int c = 0; c < 1800 && n < 1587; c++) begin
            in_valid = (sent < 1587);
            data_in  = 32'(sent);
            if (in_valid)
                sent++;
            popped = ov_def;
            if (popped) begin
                check("frm_data", do_def, 32'(n));
                check("frm_col", col_def, 32'(n % 23));
                check("frm_row", row_def, 32'((n / 23) % 23));
                check("frm_ch", ch_def, 32'(n / 529));
            end
            tick();
            if (popped)
                n++;
            check("frm_ch_done", cd_def, popped && (n % 529 == 0));
            check("frm_frame_done", fd_def, popped && (n == 1587));
        end
        in_valid = 1'b0;
        check("frm_pops", 32'(n), 1587);
        tick();
        check("frm_chd_1cyc", cd_def, 0);
        check("frm_frd_1cyc", fd_def, 0);
        check("frm_col_end", col_def, 0);
        check("frm_row_end", row_def, 0);
        check("frm_ch_end", ch_def, 0);
        check("frm_empty", ov_def, 0);
        check("frm_no_ovf", of_def, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
